// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between instruction fetch (ID 0) and data load (ID 1).
// It runs one transaction at a time, and it holds loads off while a snooped store is outstanding.
module axi_rd_arbiter #(
    parameter bit         DATA_PRIO = 1'b1,
    parameter logic [3:0] IDLE_ID   = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_arvalid,
    input  logic [31:0] inst_araddr,
    input  logic [3:0]  inst_arlen,
    output logic        inst_arready,
    output logic [31:0] inst_rdata,
    output logic        inst_rvalid,
    output logic        inst_rlast,
    input  logic        inst_rready,
    input  logic        data_arvalid,
    input  logic [31:0] data_araddr,
    input  logic [3:0]  data_arlen,
    output logic        data_arready,
    output logic [31:0] data_rdata,
    output logic        data_rvalid,
    output logic        data_rlast,
    input  logic        data_rready,
    output logic [3:0]  arbitrate_arid,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    input  logic        awvalid,
    input  logic        awready,
    input  logic        bvalid,
    input  logic        bready,
    output logic        len_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state, state_nxt;
    logic       wr_pending;
    logic       last_grant;   // 0: fetch, 1: data
    logic [3:0] beat_cnt;
    logic       inst_elig, data_elig, pick_data, grant;
    logic       rid_match, routed, beat_acc;

    assign inst_elig = inst_arvalid;
    assign data_elig = data_arvalid & ~wr_pending;
    assign rid_match = (rid == arid);
    assign routed    = (state == DATA) & rvalid & rid_match;

    assign arsize   = 3'b010;
    assign arvalid  = (state == ADDR);
    assign rready   = (state == DATA) & rid_match & (last_grant ? data_rready : inst_rready);
    assign beat_acc = rvalid & rready;

    assign inst_rvalid = routed & ~last_grant;
    assign data_rvalid = routed & last_grant;
    assign inst_rdata  = rdata;
    assign data_rdata  = rdata;
    assign inst_rlast  = rlast;
    assign data_rlast  = rlast;

    // NOTE: every signal written in this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        pick_data    = data_elig;
        grant        = 1'b0;
        inst_arready = 1'b0;
        data_arready = 1'b0;
        if (inst_elig && data_elig)
            pick_data = DATA_PRIO ? 1'b1 : ~last_grant;
        case (state)
            IDLE: begin
                if ((inst_elig || data_elig) && !reset) begin
                    grant        = 1'b1;
                    inst_arready = ~pick_data;
                    data_arready = pick_data;
                    state_nxt    = ADDR;
                end
            end
            ADDR:    if (arready) state_nxt = DATA;
            DATA:    if (beat_acc && rlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            arbitrate_arid <= IDLE_ID;
            arid           <= 4'd0;
            araddr         <= 32'd0;
            arlen          <= 4'd0;
            wr_pending     <= 1'b0;
            len_err        <= 1'b0;
            beat_cnt       <= 4'd0;
            last_grant     <= 1'b0;
        end else begin
            state <= state_nxt;

            // A new AW that coincides with a B response counts as a fresh outstanding store
            if (awvalid && awready)
                wr_pending <= 1'b1;
            else if (bvalid && bready)
                wr_pending <= 1'b0;

            if (grant) begin
                arid           <= {3'b000, pick_data};
                arbitrate_arid <= {3'b000, pick_data};
                araddr         <= pick_data ? data_araddr : inst_araddr;
                arlen          <= pick_data ? data_arlen  : inst_arlen;
                beat_cnt       <= pick_data ? data_arlen  : inst_arlen;
                last_grant     <= pick_data;
            end

            if (beat_acc) begin
                beat_cnt <= beat_cnt - 4'd1;
                if (rlast != (beat_cnt == 4'd0))
                    len_err <= 1'b1;
                if (rlast)
                    arbitrate_arid <= IDLE_ID;
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter. It runs one priority instance and one round-robin instance,
// each checked every cycle against a transaction-level reference model.
module tb_axi_rd_arbiter;
    localparam int         N_CYCLES = 4000;
    localparam logic [3:0] IDLE_ID  = 4'hF;
    localparam int         P_IDLE = 0, P_ADDR = 1, P_DATA = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset [2];
    logic        inst_arvalid [2], inst_arready [2], inst_rvalid [2], inst_rlast [2], inst_rready [2];
    logic [31:0] inst_araddr [2], inst_rdata [2];
    logic [3:0]  inst_arlen [2];
    logic        data_arvalid [2], data_arready [2], data_rvalid [2], data_rlast [2], data_rready [2];
    logic [31:0] data_araddr [2], data_rdata [2];
    logic [3:0]  data_arlen [2];
    logic [3:0]  arbitrate_arid [2], arid [2], arlen [2], rid [2];
    logic [31:0] araddr [2], rdata [2];
    logic [2:0]  arsize [2];
    logic        arvalid [2], arready [2], rlast [2], rvalid [2], rready [2];
    logic        awvalid [2], awready [2], bvalid [2], bready [2], len_err [2];

    // Instance 0 gives data priority; instance 1 uses round-robin
    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_rd_arbiter #(.DATA_PRIO(g == 0), .IDLE_ID(IDLE_ID)) dut (
            .clk(clk), .reset(reset[g]),
            .inst_arvalid(inst_arvalid[g]), .inst_araddr(inst_araddr[g]), .inst_arlen(inst_arlen[g]),
            .inst_arready(inst_arready[g]), .inst_rdata(inst_rdata[g]), .inst_rvalid(inst_rvalid[g]),
            .inst_rlast(inst_rlast[g]), .inst_rready(inst_rready[g]),
            .data_arvalid(data_arvalid[g]), .data_araddr(data_araddr[g]), .data_arlen(data_arlen[g]),
            .data_arready(data_arready[g]), .data_rdata(data_rdata[g]), .data_rvalid(data_rvalid[g]),
            .data_rlast(data_rlast[g]), .data_rready(data_rready[g]),
            .arbitrate_arid(arbitrate_arid[g]), .arid(arid[g]), .araddr(araddr[g]), .arlen(arlen[g]),
            .arsize(arsize[g]), .arvalid(arvalid[g]), .arready(arready[g]),
            .rid(rid[g]), .rdata(rdata[g]), .rlast(rlast[g]), .rvalid(rvalid[g]), .rready(rready[g]),
            .awvalid(awvalid[g]), .awready(awready[g]), .bvalid(bvalid[g]), .bready(bready[g]),
            .len_err(len_err[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input int k, input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL [%0d] %s: got 0x%0h expected 0x%0h", k, tag, got, exp);
    endtask

    // Reference model state, one set per instance
    int          m_phase [2];
    logic [3:0]  m_id [2], m_len [2];
    logic [31:0] m_addr [2];
    int          m_beats [2];
    bit          m_wp [2], m_err [2], m_last [2];

    // Stimulus and bus-slave state
    bit          sl_active [2], sl_show [2], w_out [2], mid_done [2];
    logic [3:0]  sl_id [2];
    int          sl_total [2], sl_sent [2];
    bit          o_inst_ack [2], o_data_ack [2], o_ar_hs [2], o_beat [2];
    logic [3:0]  o_arid [2], o_arlen [2];

    // Winner among eligible requesters: -1 none, 0 fetch, 1 data
    function automatic int pick(input bit ie, input bit de, input bit prio_data, input bit last);
        if (ie && de) return prio_data ? 1 : (last ? 0 : 1);
        if (de) return 1;
        if (ie) return 0;
        return -1;
    endfunction

    task automatic drive(input int k, input int cyc);
        bit rst;
        int r;
        rst = (cyc < 3) ||
              (!mid_done[k] && cyc >= 1500 + 700 * k && m_phase[k] == P_DATA && m_beats[k] >= 1);
        if (rst && cyc >= 3) mid_done[k] = 1'b1;
        reset[k] = rst;
        if (rst) begin
            inst_arvalid[k] = 0; inst_araddr[k] = 0; inst_arlen[k] = 0; inst_rready[k] = 0;
            data_arvalid[k] = 0; data_araddr[k] = 0; data_arlen[k] = 0; data_rready[k] = 0;
            arready[k] = 0; rid[k] = 0; rdata[k] = 0; rlast[k] = 0; rvalid[k] = 0;
            awvalid[k] = 0; awready[k] = 0; bvalid[k] = 0; bready[k] = 0;
            sl_active[k] = 0; sl_show[k] = 0; w_out[k] = 0;
            return;
        end

        // Requesters hold their request until they see the arready pulse
        if (!inst_arvalid[k] || o_inst_ack[k]) begin
            inst_arvalid[k] = ($urandom_range(0, 9) < 6);
            inst_araddr[k]  = $urandom;
            inst_arlen[k]   = 4'($urandom_range(0, 5));
        end
        if (!data_arvalid[k] || o_data_ack[k]) begin
            data_arvalid[k] = ($urandom_range(0, 9) < 7);
            data_araddr[k]  = $urandom;
            data_arlen[k]   = 4'($urandom_range(0, 5));
        end
        inst_rready[k] = ($urandom_range(0, 3) != 0);
        data_rready[k] = ($urandom_range(0, 3) != 0);

        // Snooped write channel, at most one store outstanding
        awvalid[k] = 0; awready[k] = 0; bvalid[k] = 0; bready[k] = 0;
        r = $urandom_range(0, 11);
        if (!w_out[k]) begin
            if (r == 0) begin awvalid[k] = 1; awready[k] = 1; w_out[k] = 1; end
            else if (r == 1) awvalid[k] = 1;
        end else begin
            if (r == 0) begin bvalid[k] = 1; bready[k] = 1; w_out[k] = 0; end
            else if (r == 1) begin bvalid[k] = 1; bready[k] = 1; awvalid[k] = 1; awready[k] = 1; end
            else if (r == 2) bvalid[k] = 1;
        end

        // Bus slave: random arready, beats with gaps, stray other-ID beats, occasional early rlast
        arready[k] = 1'($urandom_range(0, 1));
        if (o_ar_hs[k]) begin
            sl_active[k] = 1; sl_show[k] = 0; sl_id[k] = o_arid[k]; sl_sent[k] = 0;
            if (o_arlen[k] != 0 && $urandom_range(0, 5) == 0)
                sl_total[k] = $urandom_range(1, int'(o_arlen[k]));
            else
                sl_total[k] = int'(o_arlen[k]) + 1;
        end
        if (o_beat[k]) begin
            sl_sent[k]++;
            sl_show[k] = 0;
            if (sl_sent[k] == sl_total[k]) sl_active[k] = 0;
        end
        if (!sl_show[k]) begin
            rvalid[k] = 0; rlast[k] = 0; rdata[k] = $urandom;
            rid[k] = 4'($urandom_range(2, 9));
            r = $urandom_range(0, 5);
            if (r == 0) begin
                rvalid[k] = 1;
                rlast[k]  = 1'($urandom_range(0, 1));
                if (sl_active[k]) rid[k] = sl_id[k] ^ 4'd1;
            end else if (r >= 2 && sl_active[k]) begin
                rvalid[k] = 1; rid[k] = sl_id[k]; sl_show[k] = 1;
                rlast[k]  = (sl_sent[k] == sl_total[k] - 1);
            end
        end
    endtask

    task automatic check_outputs(input int k);
        int w;
        bit gr, exp_rr, exp_iv, exp_dv;
        gr = m_id[k][0];
        w  = (m_phase[k] == P_IDLE) ?
             pick(inst_arvalid[k], data_arvalid[k] & ~m_wp[k], k == 0, m_last[k]) : -1;
        exp_rr = (m_phase[k] == P_DATA) && (rid[k] == m_id[k]) && (gr ? data_rready[k] : inst_rready[k]);
        exp_iv = (m_phase[k] == P_DATA) && rvalid[k] && (rid[k] == m_id[k]) && !gr;
        exp_dv = (m_phase[k] == P_DATA) && rvalid[k] && (rid[k] == m_id[k]) && gr;

        check(k, "arbitrate_arid", 32'(arbitrate_arid[k]), 32'((m_phase[k] == P_IDLE) ? IDLE_ID : m_id[k]));
        check(k, "arvalid", 32'(arvalid[k]), 32'(m_phase[k] == P_ADDR));
        check(k, "arsize", 32'(arsize[k]), 32'd2);
        check(k, "arid", 32'(arid[k]), 32'(m_id[k]));
        check(k, "araddr", araddr[k], m_addr[k]);
        check(k, "arlen", 32'(arlen[k]), 32'(m_len[k]));
        check(k, "inst_arready", 32'(inst_arready[k]), 32'(w == 0));
        check(k, "data_arready", 32'(data_arready[k]), 32'(w == 1));
        check(k, "rready", 32'(rready[k]), 32'(exp_rr));
        check(k, "inst_rvalid", 32'(inst_rvalid[k]), 32'(exp_iv));
        check(k, "data_rvalid", 32'(data_rvalid[k]), 32'(exp_dv));
        check(k, "len_err", 32'(len_err[k]), 32'(m_err[k]));
        if (exp_iv) begin
            check(k, "inst_rdata", inst_rdata[k], rdata[k]);
            check(k, "inst_rlast", 32'(inst_rlast[k]), 32'(rlast[k]));
        end
        if (exp_dv) begin
            check(k, "data_rdata", data_rdata[k], rdata[k]);
            check(k, "data_rlast", 32'(data_rlast[k]), 32'(rlast[k]));
        end
    endtask

    task automatic model_step(input int k);
        int w;
        bit acc;
        if (reset[k]) begin
            m_phase[k] = P_IDLE; m_id[k] = 0; m_addr[k] = 0; m_len[k] = 0;
            m_wp[k] = 0; m_err[k] = 0; m_last[k] = 0; m_beats[k] = 0;
            return;
        end
        w   = pick(inst_arvalid[k], data_arvalid[k] & ~m_wp[k], k == 0, m_last[k]);
        acc = (m_phase[k] == P_DATA) && rvalid[k] && (rid[k] == m_id[k]) &&
              (m_id[k][0] ? data_rready[k] : inst_rready[k]);
        case (m_phase[k])
            P_IDLE: if (w >= 0) begin
                m_id[k]    = 4'(w);
                m_addr[k]  = (w == 1) ? data_araddr[k] : inst_araddr[k];
                m_len[k]   = (w == 1) ? data_arlen[k]  : inst_arlen[k];
                m_last[k]  = (w == 1);
                m_beats[k] = 0;
                m_phase[k] = P_ADDR;
            end
            P_ADDR: if (arready[k]) m_phase[k] = P_DATA;
            default: if (acc) begin
                if (rlast[k] != ((m_beats[k] & 15) == int'(m_len[k]))) m_err[k] = 1;
                m_beats[k]++;
                if (rlast[k]) m_phase[k] = P_IDLE;
            end
        endcase
        if (awvalid[k] && awready[k]) m_wp[k] = 1;
        else if (bvalid[k] && bready[k]) m_wp[k] = 0;
    endtask

    task automatic observe(input int k);
        o_inst_ack[k] = inst_arready[k];
        o_data_ack[k] = data_arready[k];
        o_ar_hs[k]    = arvalid[k] & arready[k];
        o_beat[k]     = sl_show[k] & rvalid[k] & rready[k];
        o_arid[k]     = arid[k];
        o_arlen[k]    = arlen[k];
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1; inst_arvalid[k] = 0; data_arvalid[k] = 0;
            m_phase[k] = P_IDLE; m_beats[k] = 0;
        end
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) drive(k, cyc);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!reset[k]) check_outputs(k);
                model_step(k);
                observe(k);
            end
        end
        for (int k = 0; k < 2; k++) check(k, "mid_reset_hit", 32'(mid_done[k]), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
